// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the clocked +1 reference pipeline.
//   CNT_W : width of the output transfer counter
//   MAX_W : widest data path the inc() helper supports
//   inc() : returns x+1; callers truncate the result to their own width,
//           which gives modulo-2^WIDTH wrap with no carry out.
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int CNT_W = 16;
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] inc(input logic [MAX_W-1:0] x);
        return x + MAX_W'(1);
    endfunction

endpackage

// File: rtl/seq_inc_stage.sv
// -----------------------------------------------------------------------------
// seq_inc_stage
// One valid/ready register slot that stores (upstream value + 1).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   up_valid/up_ready   upstream handshake (up_ready is combinational)
//   up_data             upstream value
//   dn_valid/dn_ready   downstream handshake (dn_valid is registered)
//   dn_data             registered up_data + 1 (mod 2^WIDTH)
// -----------------------------------------------------------------------------
module seq_inc_stage
    import seq_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic load;

    // Accept when empty or when the held item leaves this same cycle; this
    // lets bubbles collapse and keeps full throughput.
    assign up_ready = ~dn_valid | dn_ready;
    assign load     = up_valid & up_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (load) begin
            dn_valid <= 1'b1;
            dn_data  <= WIDTH'(inc(MAX_W'(up_data)));
        end else if (dn_ready) begin
            dn_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_inc_pipe.sv
// -----------------------------------------------------------------------------
// seq_inc_pipe
// Clocked reference for a +1 chain: STAGES register stages, each adding 1
// modulo 2^WIDTH, joined by valid/ready handshakes.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     source handshake
//   in_data               source value
//   out_valid/out_ready   sink handshake
//   out_data              in_data + STAGES (mod 2^WIDTH)
//   tap_data/tap_valid    per-stage value and valid (stage 1 at the LSBs)
//   occupancy             number of occupied stages
//   xfer_cnt              completed output transfers (wraps)
// -----------------------------------------------------------------------------
module seq_inc_pipe
    import seq_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [STAGES*WIDTH-1:0]     tap_data,
    output logic [STAGES-1:0]           tap_valid,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [CNT_W-1:0]            xfer_cnt
);

    localparam int OCC_W = $clog2(STAGES+1);

    // Index 0 of each chain is the source side, index STAGES the sink side.
    logic [STAGES:0]             v_chain;
    logic [STAGES:0]             r_chain;
    logic [(STAGES+1)*WIDTH-1:0] d_chain;
    logic                        in_acc;
    logic                        out_xfer;

    assign v_chain[0]           = in_valid;
    assign d_chain[WIDTH-1:0]   = in_data;
    assign r_chain[STAGES]      = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        seq_inc_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (v_chain[k]),
            .up_ready (r_chain[k]),
            .up_data  (d_chain[k*WIDTH +: WIDTH]),
            .dn_valid (v_chain[k+1]),
            .dn_ready (r_chain[k+1]),
            .dn_data  (d_chain[(k+1)*WIDTH +: WIDTH])
        );
    end

    // Held low while reset is asserted so nothing is accepted in that cycle.
    assign in_ready  = rst_n & r_chain[0];
    assign out_valid = v_chain[STAGES];
    assign out_data  = d_chain[STAGES*WIDTH +: WIDTH];
    assign tap_valid = v_chain[STAGES:1];
    assign tap_data  = d_chain[(STAGES+1)*WIDTH-1:WIDTH];

    assign in_acc   = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
            xfer_cnt  <= '0;
        end else begin
            case ({in_acc, out_xfer})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
            if (out_xfer) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_inc_pipe.sv
// -----------------------------------------------------------------------------
// tb_seq_inc_pipe
// Scoreboard bench: the stimulus process pushes the expected output of each
// accepted item into a queue; a monitor pops and compares on every output
// transfer. A second instance (WIDTH=8) covers the wrap case.
// -----------------------------------------------------------------------------
module tb_seq_inc_pipe;

    localparam int ST = 4;

    logic        clk;
    logic        rst_n;

    // WIDTH=1 instance
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_data;
    logic [3:0]  tap_data;
    logic [3:0]  tap_valid;
    logic [2:0]  occupancy;
    logic [15:0] xfer_cnt;

    // WIDTH=8 instance
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_out_data;
    logic [31:0] b_tap_data;
    logic [3:0]  b_tap_valid;
    logic [2:0]  b_occupancy;
    logic [15:0] b_xfer_cnt;

    int checks = 0;
    int passes = 0;
    int mon_xfers = 0;
    int xfer_base = 0;
    logic [0:0] exp_q[$];

    seq_inc_pipe #(.WIDTH(1), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .tap_data  (tap_data),
        .tap_valid (tap_valid),
        .occupancy (occupancy),
        .xfer_cnt  (xfer_cnt)
    );

    seq_inc_pipe #(.WIDTH(8), .STAGES(ST)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .tap_data  (b_tap_data),
        .tap_valid (b_tap_valid),
        .occupancy (b_occupancy),
        .xfer_cnt  (b_xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Present one item, wait (bounded) for acceptance, record its expected
    // output. Returns just after the accepting edge with in_valid still high.
    task automatic send(input logic [0:0] d, input logic [0:0] e);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout: got no accept, expected accept within 64 cycles");
        end
    endtask

    // Monitor: output transfers, hold stability under stall, occupancy bound.
    initial begin : monitor
        bit         stall_prev = 1'b0;
        logic [0:0] held = '0;
        logic [0:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) begin
                    check("hold_valid", 64'(out_valid), 64'(1));
                    check("hold_data", 64'(out_data), 64'(held));
                end
                check("occ_bound", 64'(occupancy <= 3'(ST)), 64'(1));
                if (out_valid && out_ready) begin
                    mon_xfers++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_output: got %0h, expected no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 64'(out_data), 64'(e));
                    end
                end
                stall_prev = out_valid && !out_ready;
                held       = out_data;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [3:0]  t1_exp;
        logic [31:0] t4_exp;
        logic [0:0]  d;
        bit          acc;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_tap_valid", 64'(tap_valid), 64'(0));
        check("rst_tap_data", 64'(tap_data), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
        check("rst_in_ready_low", 64'(in_ready), 64'(0));
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'(1));

        // Test 1: single pulse of 1 through four +1 stages (WIDTH=1)
        t1_exp = 4'b1010;          // stage1..4 = 0,1,0,1
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 1'b1;
        @(negedge clk);
        check("t1_in_ready", 64'(in_ready), 64'(1));
        exp_q.push_back(1'b1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("t1_tap_valid", 64'(tap_valid), 64'(4'b0001 << k));
            check("t1_tap_data", 64'(tap_data[k]), 64'(t1_exp[k]));
            check("t1_out_valid", 64'(out_valid), 64'(k == 3));
        end
        check("t1_out_data", 64'(out_data), 64'(1));
        @(posedge clk);
        #1;
        check("t1_out_valid_after", 64'(out_valid), 64'(0));
        check("t1_xfer_cnt", 64'(xfer_cnt), 64'(1));

        // Test 2: back-to-back 0,1,0,1,... with out_ready held high
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 1'(i % 2);
            @(negedge clk);
            check("t2_in_ready", 64'(in_ready), 64'(1));
            exp_q.push_back(1'(i % 2));   // +4 on one bit is the identity
            if (i >= 4) begin
                check("t2_occupancy", 64'(occupancy), 64'(4));
                check("t2_out_valid", 64'(out_valid), 64'(1));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t2_drained_occ", 64'(occupancy), 64'(0));
        check("t2_queue_empty", 64'(exp_q.size()), 64'(0));
        check("t2_xfer_cnt", 64'(xfer_cnt), 64'(13));

        // Test 3: six cycles of out_ready=0 while streaming
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'((i + 1) % 2), 1'((i + 1) % 2));
        in_valid = 1'b1;
        in_data  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t3_in_ready_low", 64'(in_ready), 64'(0));
            check("t3_occupancy", 64'(occupancy), 64'(4));
            check("t3_out_valid", 64'(out_valid), 64'(1));
            check("t3_out_data_held", 64'(out_data), 64'(1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(1'((i + 1) % 2), 1'((i + 1) % 2));
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("t3_queue_empty", 64'(exp_q.size()), 64'(0));
        check("t3_xfer_cnt", 64'(xfer_cnt), 64'(21));

        // Test 4: WIDTH=8 wrap, 0xFE -> FF,00,01,02
        t4_exp = 32'h0201_00FF;
        b_in_valid = 1'b1;
        b_in_data  = 8'hFE;
        @(negedge clk);
        check("t4_in_ready", 64'(b_in_ready), 64'(1));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            b_in_valid = 1'b0;
            check("t4_tap_data", 64'(b_tap_data[k*8 +: 8]), 64'(t4_exp[k*8 +: 8]));
            check("t4_tap_valid", 64'(b_tap_valid), 64'(4'b0001 << k));
            check("t4_out_valid", 64'(b_out_valid), 64'(k == 3));
        end
        check("t4_out_data", 64'(b_out_data), 64'(8'h02));
        @(posedge clk);
        #1;
        check("t4_xfer_cnt", 64'(b_xfer_cnt), 64'(1));

        // Test 5: reset with three items in flight
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        in_valid = 1'b0;
        check("t5_inflight", 64'(tap_valid), 64'(4'b0111));
        rst_n = 1'b0;
        #1;
        check("t5_tap_valid", 64'(tap_valid), 64'(0));
        check("t5_occupancy", 64'(occupancy), 64'(0));
        check("t5_out_valid", 64'(out_valid), 64'(0));
        check("t5_in_ready", 64'(in_ready), 64'(0));
        exp_q.delete();
        xfer_base = mon_xfers;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_xfer_cnt", 64'(xfer_cnt), 64'(0));
        send(1'b1, 1'b1);
        in_valid = 1'b0;
        check("t5_lat_early", 64'(out_valid), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("t5_lat_out_valid", 64'(out_valid), 64'(1));
        check("t5_lat_tap_valid", 64'(tap_valid), 64'(4'b1000));
        check("t5_lat_out_data", 64'(out_data), 64'(1));
        repeat (2) @(posedge clk);
        #1;

        // Test 6: random in_valid/out_ready against the queue model
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(1'(32'(in_data) + ST));
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                d        = 1'($urandom);
                in_data  = d;
            end
        end
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(1'(32'(in_data) + ST));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t6_queue_empty", 64'(exp_q.size()), 64'(0));
        check("t6_occupancy", 64'(occupancy), 64'(0));
        check("t6_xfer_cnt", 64'(xfer_cnt), 64'(16'(mon_xfers - xfer_base)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
